md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers, placed in the E stage of the 5-stage pipeline.
- Parametrised in operand width and in multiply and divide latency.
- Exposes start and busy so the hazard unit can stall D-stage instructions that use the unit (mult/div/mfhi/mflo/mthi/mtlo) while an operation is in flight.
- Provides a kill input so an in-flight operation can be aborted. This adds abort capability to the fixed-latency pipeline.

---
 rtl/md_unit_pkg.sv | 30 +++
 rtl/md_unit_if.sv | 24 ++
 rtl/md_core.sv | 72 +++++++
 rtl/md_unit.sv | 126 ++++++++++++
 tb/tb_md_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit. The hazard unit's md-stall rule
// imports these same op constants.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Ops 0..3 occupy the unit for a multi-cycle mult/div.
  function automatic logic is_arith(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request / HI-LO result bundle of the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, kill,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, kill,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_core.sv
// Combinational mult/div result generator, including the divide-by-zero and
// signed-overflow corner cases.
module md_core
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   quot_u;
  logic        [WIDTH-1:0]   rem_u;
  logic                      div_zero;
  logic                      div_ovf;

  assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Raw quotients are garbage for the corner cases; those are muxed out below.
  assign quot_s = $signed(a_i) / $signed(b_i);
  assign rem_s  = $signed(a_i) % $signed(b_i);
  assign quot_u = a_i / b_i;
  assign rem_u  = a_i % b_i;

  assign div_zero = (b_i == '0);
  assign div_ovf  = (a_i == MinVal) && (b_i == '1);

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s;
      MD_MULTU: {hi_o, lo_o} = prod_u;
      MD_DIV: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = '1;
        end else if (div_ovf) begin
          hi_o = '0;
          lo_o = MinVal;
        end else begin
          hi_o = rem_s;
          lo_o = quot_s;
        end
      end
      MD_DIVU: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = '1;
        end else begin
          hi_o = rem_u;
          lo_o = quot_u;
        end
      end
      default: begin
        hi_o = '0;
        lo_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy/done handshake
// for the hazard unit, and kill to abort an in-flight operation.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  md_op_e           req_op;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign req_op = md_op_e'(md.op);
  // kill beats start when both arrive in IDLE.
  assign accept = (state_q == MD_IDLE) && md.start && !md.kill;
  assign last   = (state_q == MD_RUN) && (cnt_q == '0);

  md_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (accept && is_arith(req_op)) state_d = MD_RUN;
      MD_RUN:  if (md.kill || last) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    md.busy = (state_q == MD_RUN);
    md.done = done_q;
    md.hi   = hi_q;
    md.lo   = lo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (accept) begin
      if (is_arith(req_op)) begin
        op_d  = req_op;
        a_d   = md.src_a;
        b_d   = md.src_b;
        cnt_d = is_mult(req_op) ? MultLoad : DivLoad;
      end else if (req_op == MD_MTHI) begin
        hi_d = md.src_a;
      end else if (req_op == MD_MTLO) begin
        lo_d = md.src_a;
      end
    end else if (state_q == MD_RUN) begin
      if (md.kill) begin
        cnt_d = '0;
      end else if (last) begin
        hi_d   = res_hi;
        lo_d   = res_lo;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      op_q   <= MD_MULT;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: cycle-level behavioural model plus directed
// scenarios with literal expectations.
module tb_md_unit;

  localparam int unsigned W      = 32;
  localparam int          MULT_N = 5;
  localparam int          DIV_N  = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  md_unit_if #(.WIDTH(W)) mif ();

  md_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic in 64-bit integers.
  function automatic logic [63:0] model_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  int          rem;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem    <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (rem == 0) begin
        if (mif.start && !mif.kill) begin
          if (mif.op <= 3'd3) begin
            rem  <= (mif.op <= 3'd1) ? MULT_N : DIV_N;
            m_op <= mif.op;
            m_a  <= mif.src_a;
            m_b  <= mif.src_b;
          end else if (mif.op == 3'd4) begin
            m_hi <= mif.src_a;
          end else if (mif.op == 3'd5) begin
            m_lo <= mif.src_a;
          end
        end
      end else if (mif.kill) begin
        rem <= 0;
      end else if (rem == 1) begin
        {m_hi, m_lo} <= model_result(m_op, m_a, m_b);
        m_done       <= 1'b1;
        rem          <= 0;
      end else begin
        rem <= rem - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", 64'(mif.busy), 64'(rem != 0));
    chk("model_done", 64'(mif.done), 64'(m_done));
    chk("model_hi", 64'(mif.hi), 64'(m_hi));
    chk("model_lo", 64'(mif.lo), 64'(m_lo));
    chk("done_while_busy", 64'(mif.done & mif.busy), 64'd0);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1;
    mif.op    = op;
    mif.src_a = a;
    mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (mif.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    mif.start = 1'b0;
    mif.op    = 3'd0;
    mif.src_a = '0;
    mif.src_b = '0;
    mif.kill  = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(mif.busy), 64'd0);
    chk("reset_done", 64'(mif.done), 64'd0);
    chk("reset_hilo", {mif.hi, mif.lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    chk("model_pin_mult", model_result(3'd0, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
    chk("model_pin_div", model_result(3'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    // MULT -2 * 3
    chk("idle_before", 64'(mif.busy), 64'd0);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_busy(n);
    chk("mult_busy_len", 64'(n), 64'd5);
    chk("mult_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_done", 64'(mif.done), 64'd1);
    @(negedge clk);
    chk("mult_done_pulse", 64'(mif.done), 64'd0);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_busy(n);
    chk("div_busy_len", 64'(n), 64'd10);
    chk("div_hilo", {mif.hi, mif.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU by zero, then DIV overflow launched in the cycle busy falls
    issue(3'd3, 32'h1234_5678, 32'd0);
    run_busy(n);
    chk("divu_zero_hilo", {mif.hi, mif.lo}, 64'h1234_5678_FFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("b2b_busy", 64'(mif.busy), 64'd1);
    run_busy(n);
    chk("b2b_busy_len", 64'(n), 64'd10);
    chk("div_ovf_hilo", {mif.hi, mif.lo}, 64'h0000_0000_8000_0000);

    // MTHI then MTLO on consecutive cycles
    mif.start = 1'b1;
    mif.op    = 3'd4;
    mif.src_a = 32'hAAAA_0000;
    @(negedge clk);
    chk("mthi_hi", 64'(mif.hi), 64'h0000_0000_AAAA_0000);
    chk("mthi_busy", 64'(mif.busy), 64'd0);
    mif.op    = 3'd5;
    mif.src_a = 32'h0000_5555;
    @(negedge clk);
    mif.start = 1'b0;
    chk("mtlo_hilo", {mif.hi, mif.lo}, 64'hAAAA_0000_0000_5555);
    chk("mtlo_busy", 64'(mif.busy), 64'd0);
    chk("mtlo_done", 64'(mif.done), 64'd0);

    // MULTU with a second start while busy
    issue(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    issue(3'd1, 32'd7, 32'd7);
    run_busy(n);
    chk("ignore_busy_len", 64'(n), 64'd3);
    chk("ignore_hilo", {mif.hi, mif.lo}, 64'd15);
    @(negedge clk);
    chk("ignore_no_second", 64'(mif.busy), 64'd0);

    // Kill in busy cycle 3
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    mif.kill = 1'b1;
    @(negedge clk);
    mif.kill = 1'b0;
    chk("kill3_busy", 64'(mif.busy), 64'd0);
    chk("kill3_hilo", {mif.hi, mif.lo}, 64'd15);
    repeat (6) @(negedge clk);
    chk("kill3_done", 64'(mif.done), 64'd0);

    // Kill in the final busy cycle
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    mif.kill = 1'b1;
    @(negedge clk);
    mif.kill = 1'b0;
    chk("killlast_busy", 64'(mif.busy), 64'd0);
    chk("killlast_done", 64'(mif.done), 64'd0);
    chk("killlast_hilo", {mif.hi, mif.lo}, 64'd15);

    // kill with start in IDLE, then a no-op start
    mif.kill = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    mif.kill = 1'b0;
    chk("kill_start_hi", 64'(mif.hi), 64'd0);
    issue(3'd6, 32'h1234, 32'd1);
    chk("nop_busy", 64'(mif.busy), 64'd0);
    chk("nop_hilo", {mif.hi, mif.lo}, 64'd15);

    // Asynchronous reset mid-DIV
    issue(3'd2, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(mif.busy), 64'd0);
    chk("async_rst_done", 64'(mif.done), 64'd0);
    chk("async_rst_hilo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3'd0, 32'd6, 32'd7);
    run_busy(n);
    chk("post_rst_len", 64'(n), 64'd5);
    chk("post_rst_hilo", {mif.hi, mif.lo}, 64'd42);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
